wb_dmx_tx: RTL

WB_DMX_TX -- requirements
Module: wb_dmx_tx

---
 rtl/wb_dmx_tx.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_dmx_tx.sv
// DMX512 transmitter behind a Wishbone classic slave: CTRL/STATUS/TIMING/SLOTS
// registers plus a 64-entry channel buffer, serialised as break, MAB, start code, slots.
module wb_dmx_tx #(
  parameter int unsigned clk_freq = 100000000,
  parameter int unsigned baud     = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        dmx_tx,
  output logic        dmx_de,
  output logic        intr
);

  localparam int unsigned BIT_CLKS = clk_freq / baud;
  localparam int unsigned DIV_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CLKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_MAB,
    ST_SLOT
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       per_cnt;
  logic [3:0]       bit_idx;
  logic [6:0]       slot_idx;
  logic [6:0]       nslots;
  logic [7:0]       brk_len;
  logic [7:0]       mab_len;
  logic [7:0]       shreg;

  logic [7:0]       chan_buf [64];
  logic             ctrl_enable;
  logic             ctrl_cont;
  logic             ctrl_irq_en;
  logic             done;
  logic             go_pending;
  logic [15:0]      timing;
  logic [6:0]       slots;

  logic             req;
  logic             req_d;
  logic             acc_start;
  logic             wr_en;
  logic             reg_wr;
  logic             done_clr;
  logic             go_wr;
  logic             busy;
  logic             bit_tick;
  logic             slot_done;
  logic             frame_end;
  logic             want_frame;
  logic             start_frame;
  logic [7:0]       brk_eff;
  logic [7:0]       mab_eff;
  logic [6:0]       slots_eff;
  logic [31:0]      rd_data;
  logic             unused_ok;

  assign unused_ok = ^{wb_adr_i[31:9], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:16]};

  assign dmx_de = ctrl_enable;
  assign intr   = done & ctrl_irq_en;

  always_comb begin
    req         = wb_stb_i & wb_cyc_i;
    // Ack only on the rising edge of the request so a held strobe never gets a second ack.
    acc_start   = req & ~req_d;
    wr_en       = acc_start & wb_we_i & wb_sel_i[0];
    reg_wr      = wr_en & ~wb_adr_i[8];
    done_clr    = reg_wr & (wb_adr_i[3:2] == 2'd1) & wb_dat_i[1];
    go_wr       = reg_wr & (wb_adr_i[3:2] == 2'd0) & wb_dat_i[3];
    busy        = (state != ST_IDLE);
    bit_tick    = (div_cnt == DIV_LAST);
    slot_done   = (state == ST_SLOT) & bit_tick & (bit_idx == 4'd10);
    frame_end   = slot_done & (slot_idx == nslots);
    want_frame  = ctrl_enable & (ctrl_cont | go_pending);
    start_frame = want_frame & ((state == ST_IDLE) | frame_end);
    brk_eff     = (timing[7:0] == 8'd0) ? 8'd1 : timing[7:0];
    mab_eff     = (timing[15:8] == 8'd0) ? 8'd1 : timing[15:8];
    if (slots == 7'd0)
      slots_eff = 7'd1;
    else if (slots > 7'd64)
      slots_eff = 7'd64;
    else
      slots_eff = slots;
  end

  always_comb begin
    rd_data = '0;
    if (wb_adr_i[8]) begin
      rd_data[7:0] = chan_buf[wb_adr_i[7:2]];
    end else begin
      case (wb_adr_i[3:2])
        2'd0:    rd_data[2:0]  = {ctrl_irq_en, ctrl_cont, ctrl_enable};
        2'd1:    rd_data[1:0]  = {done, busy};
        2'd2:    rd_data[15:0] = timing;
        default: rd_data[6:0]  = slots;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d       <= 1'b0;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      ctrl_enable <= 1'b0;
      ctrl_cont   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      done        <= 1'b0;
      go_pending  <= 1'b0;
      timing      <= 16'h0317;
      slots       <= 7'd64;
    end else begin
      req_d      <= req;
      wb_ack_o   <= acc_start;
      wb_dat_o   <= (acc_start && !wb_we_i) ? rd_data : '0;
      // Set wins over clear; a go arriving as the previous one is consumed stays pending.
      done       <= (done & ~done_clr) | frame_end;
      go_pending <= (go_pending & ~start_frame) | go_wr;
      if (reg_wr) begin
        case (wb_adr_i[3:2])
          2'd0: begin
            ctrl_enable <= wb_dat_i[0];
            ctrl_cont   <= wb_dat_i[1];
            ctrl_irq_en <= wb_dat_i[2];
          end
          2'd2:    timing <= wb_dat_i[15:0];
          2'd3:    slots  <= wb_dat_i[6:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && wb_adr_i[8])
      chan_buf[wb_adr_i[7:2]] <= wb_dat_i[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      per_cnt  <= '0;
      bit_idx  <= '0;
      slot_idx <= '0;
      nslots   <= 7'd1;
      brk_len  <= 8'd1;
      mab_len  <= 8'd1;
      shreg    <= '0;
      dmx_tx   <= 1'b1;
    end else begin
      div_cnt <= bit_tick ? '0 : div_cnt + 1'b1;
      if (start_frame) begin
        // Frame parameters are sampled only here, so register writes mid-frame wait.
        state   <= ST_BREAK;
        div_cnt <= '0;
        per_cnt <= '0;
        brk_len <= brk_eff;
        mab_len <= mab_eff;
        nslots  <= slots_eff;
        dmx_tx  <= 1'b0;
      end else begin
        case (state)
          ST_BREAK: begin
            if (bit_tick) begin
              if (per_cnt == brk_len - 8'd1) begin
                state   <= ST_MAB;
                per_cnt <= '0;
                dmx_tx  <= 1'b1;
              end else begin
                per_cnt <= per_cnt + 8'd1;
              end
            end
          end
          ST_MAB: begin
            if (bit_tick) begin
              if (per_cnt == mab_len - 8'd1) begin
                state    <= ST_SLOT;
                per_cnt  <= '0;
                slot_idx <= '0;
                bit_idx  <= '0;
                shreg    <= 8'h00;
                dmx_tx   <= 1'b0;
              end else begin
                per_cnt <= per_cnt + 8'd1;
              end
            end
          end
          ST_SLOT: begin
            if (bit_tick) begin
              if (bit_idx == 4'd10) begin
                if (slot_idx == nslots) begin
                  state  <= ST_IDLE;
                  dmx_tx <= 1'b1;
                end else begin
                  slot_idx <= slot_idx + 7'd1;
                  bit_idx  <= '0;
                  shreg    <= chan_buf[slot_idx[5:0]];
                  dmx_tx   <= 1'b0;
                end
              end else begin
                bit_idx <= bit_idx + 4'd1;
                dmx_tx  <= (bit_idx < 4'd8) ? shreg[bit_idx[2:0]] : 1'b1;
              end
            end
          end
          default: dmx_tx <= 1'b1;
        endcase
      end
    end
  end

endmodule
